// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: filters two resolved-branch lanes into insert/invalidate
// commands, queues them, drains one per cycle, and runs full-table invalidate sweeps.
module btb_update_ctrl #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int Q_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              res_valid,
  input  logic [1:0][XLEN-1:0]    res_pc,
  input  logic [1:0][XLEN-1:0]    res_target,
  input  logic [1:0]              res_taken,
  input  logic [1:0]              res_mispred,
  output logic                    res_ready,
  input  logic                    flush_all_req,
  output logic                    btb_wr_en,
  output logic [IDX_BITS-1:0]     btb_wr_idx,
  output logic [XLEN-1:0]         btb_wr_pc,
  output logic [XLEN-1:0]         btb_wr_target,
  output logic                    btb_wr_valid,
  output logic                    busy
);

  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     target;
    logic                valid;
  } cmd_t;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_BITS:0]   r_sidx, w_sidx_nxt;
  cmd_t                r_mem [Q_DEPTH];
  logic [PW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]       r_cnt;

  logic                r_wr_en;
  cmd_t                r_wr_cmd;

  logic [1:0]          w_lvld;
  cmd_t [1:0]          w_lane;
  cmd_t [1:0]          w_new;
  logic [1:0]          w_nnew;
  cmd_t [1:0]          w_enq;
  logic [1:0]          w_enq_n;
  logic                w_pop, w_bypass, w_kill0;
  cmd_t                w_out_cmd;
  logic                w_wr_en_nxt;
  cmd_t                w_wr_cmd_nxt;

  assign res_ready = ((CW'(Q_DEPTH) - r_cnt) >= CW'(2)) && (r_state == S_IDLE) && !flush_all_req;
  assign busy      = (r_cnt != '0) || (r_state == S_SWEEP);

  // Per-lane filter: taken -> insert, not-taken mispredict -> invalidate, else nothing.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    assign w_lvld[l] = res_valid[l] & res_ready & (res_taken[l] | res_mispred[l]);
    assign w_lane[l] = '{idx:    res_pc[l][IDX_BITS+1:2],
                         pc:     res_taken[l] ? res_pc[l] : '0,
                         target: res_taken[l] ? res_target[l] : '0,
                         valid:  res_taken[l]};
  end

  // Lane 1 wins when both lanes hit the same index in one cycle.
  assign w_kill0 = w_lvld[0] & w_lvld[1] & (w_lane[0].idx == w_lane[1].idx);

  always_comb begin
    w_new  = w_lane;
    w_nnew = 2'd0;
    if (w_lvld[0] && !w_kill0) begin
      w_nnew = w_lvld[1] ? 2'd2 : 2'd1;
    end else begin
      w_new[0] = w_lane[1];
      w_nnew   = {1'b0, w_lvld[1]};
    end
  end

  // Empty queue: the first new command goes straight to the write port.
  assign w_pop     = (r_state == S_IDLE) && !flush_all_req && (r_cnt != '0);
  assign w_bypass  = (r_state == S_IDLE) && !flush_all_req && (r_cnt == '0) && (w_nnew != 2'd0);
  assign w_out_cmd = w_pop ? r_mem[r_rd_ptr] : w_new[0];

  always_comb begin
    w_enq   = w_new;
    w_enq_n = w_nnew;
    if (w_bypass) begin
      w_enq[0] = w_new[1];
      w_enq_n  = w_nnew - 2'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sidx_nxt   = r_sidx;
    w_wr_en_nxt  = 1'b0;
    w_wr_cmd_nxt = w_out_cmd;
    if (flush_all_req) begin
      w_state_nxt  = S_SWEEP;
      w_sidx_nxt   = (IDX_BITS+1)'(1);
      w_wr_en_nxt  = 1'b1;
      w_wr_cmd_nxt = '0;
    end else if (r_state == S_SWEEP) begin
      if (r_sidx[IDX_BITS]) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_sidx_nxt       = r_sidx + 1'b1;
        w_wr_en_nxt      = 1'b1;
        w_wr_cmd_nxt     = '0;
        w_wr_cmd_nxt.idx = r_sidx[IDX_BITS-1:0];
      end
    end else begin
      w_wr_en_nxt = w_pop | w_bypass;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sidx   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
      r_wr_en  <= 1'b0;
      r_wr_cmd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sidx  <= w_sidx_nxt;
      r_wr_en <= w_wr_en_nxt;
      if (w_wr_en_nxt) r_wr_cmd <= w_wr_cmd_nxt;
      if (flush_all_req) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PW'(w_enq_n);
        r_rd_ptr <= r_rd_ptr + PW'(w_pop);
        r_cnt    <= r_cnt + CW'(w_enq_n) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!flush_all_req && !reset) begin
      if (w_enq_n != 2'd0) r_mem[r_wr_ptr] <= w_enq[0];
      if (w_enq_n == 2'd2) r_mem[r_wr_ptr + PW'(1)] <= w_enq[1];
    end
  end

  assign btb_wr_en     = r_wr_en;
  assign btb_wr_idx    = r_wr_cmd.idx;
  assign btb_wr_pc     = r_wr_cmd.pc;
  assign btb_wr_target = r_wr_cmd.target;
  assign btb_wr_valid  = r_wr_cmd.valid;

endmodule
